// File: rtl/vm_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : vm_defs (package)
//  Brief   : Shared word width and reset word for the vending-machine datapath.
//  Rev     : 1.0
// ============================================================================
package vm_defs;

   localparam int          VM_DATA_W    = 8;
   localparam logic [31:0] VM_RESET_VAL = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/vm_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module  : vm_pipe_stage
//  Brief   : One {valid,data} slice of the stallable register pipeline.
//  Rev     : 1.0
// ============================================================================
module vm_pipe_stage
   import vm_defs::*;
#(
   parameter int               WIDTH     = VM_DATA_W,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(VM_RESET_VAL)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] prev_data,
   input  logic             rdy_in,
   output logic             rdy_out,
   output logic             valid,
   output logic             valid_nxt,
   output logic [WIDTH-1:0] data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // An empty slice always accepts, so bubbles collapse behind a stall.
   assign rdy_out = !r_valid | rdy_in;

   always_comb begin
      valid_nxt = r_valid;
      if (clr) begin
         valid_nxt = 1'b0;
      end else if (rdy_out) begin
         valid_nxt = prev_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= RESET_VAL;
      end else begin
         r_valid <= valid_nxt;
         if (clr) begin
            r_data <= RESET_VAL;
         end else if (rdy_out && prev_valid) begin
            r_data <= prev_data;
         end
      end
   end

   assign valid = r_valid;
   assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/vm_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module  : vm_pipe_reg
//  Brief   : DEPTH-stage valid/ready register pipeline with flush and occupancy.
//  Rev     : 1.0
// ============================================================================
module vm_pipe_reg
   import vm_defs::*;
#(
   parameter int               WIDTH     = VM_DATA_W,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(VM_RESET_VAL)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int c_OCC_W = $clog2(DEPTH+1);

   // Index 0 is the upstream side; index DEPTH is the output side.
   logic [DEPTH:0]            w_rdy;
   logic [DEPTH:0]            w_vchain;
   logic [DEPTH:0][WIDTH-1:0] w_dchain;
   logic [DEPTH-1:0]          w_v_nxt;
   logic [c_OCC_W-1:0]        w_occ_nxt;
   logic [c_OCC_W-1:0]        r_occ;

   assign w_rdy[DEPTH] = out_ready;
   assign in_ready     = w_rdy[0];
   assign w_vchain[0]  = in_valid;
   assign w_dchain[0]  = in_data;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         vm_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .prev_valid (w_vchain[gi]),
            .prev_data  (w_dchain[gi]),
            .rdy_in     (w_rdy[gi+1]),
            .rdy_out    (w_rdy[gi]),
            .valid      (w_vchain[gi+1]),
            .valid_nxt  (w_v_nxt[gi]),
            .data       (w_dchain[gi+1])
         );
      end
   endgenerate

   // Counting next-state valids keeps occupancy aligned with the valid bits.
   always_comb begin
      w_occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ_nxt = w_occ_nxt + c_OCC_W'(w_v_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ <= '0;
      end else begin
         r_occ <= w_occ_nxt;
      end
   end

   assign out_valid = w_vchain[DEPTH];
   assign out_data  = w_dchain[DEPTH];
   assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_vm_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module  : tb_vm_pipe_reg
//  Brief   : Scoreboard bench for vm_pipe_reg (DEPTH=2 and DEPTH=4 instances).
//  Rev     : 1.0
// ============================================================================
module tb_vm_pipe_reg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [1:0]  occupancy;

   logic        q_in_valid = 1'b0;
   logic        q_in_ready;
   logic [15:0] q_in_data = 16'h0000;
   logic        q_out_valid;
   logic        q_out_ready = 1'b0;
   logic [15:0] q_out_data;
   logic [2:0]  q_occupancy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] sb_q[$];
   logic [7:0] sb_exp;

   always #5 clk = ~clk;

   vm_pipe_reg #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h00)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   vm_pipe_reg #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'hFFFF)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (q_in_valid),
      .in_ready  (q_in_ready),
      .in_data   (q_in_data),
      .out_valid (q_out_valid),
      .out_ready (q_out_ready),
      .out_data  (q_out_data),
      .occupancy (q_occupancy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: words accepted upstream must leave downstream in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               sb_exp = sb_q.pop_front();
               chk("sb_data", 32'(out_data), 32'(sb_exp));
            end
         end
         if (clr) begin
            sb_q.delete();
         end else if (in_valid && in_ready) begin
            sb_q.push_back(in_data);
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h00);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_out_data4", 32'(q_out_data), 32'hFFFF);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Streaming with two-cycle latency and no bubbles
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      tick();
      chk("str_lat_valid", 32'(out_valid), 32'd0);
      in_data = 8'h22;
      tick();
      chk("str_w0", 32'(out_data), 32'h11);
      chk("str_v0", 32'(out_valid), 32'd1);
      in_data = 8'h33;
      tick();
      chk("str_w1", 32'(out_data), 32'h22);
      in_valid = 1'b0;
      tick();
      chk("str_w2", 32'(out_data), 32'h33);
      chk("str_v2", 32'(out_valid), 32'd1);
      tick();
      chk("str_drained", 32'(out_valid), 32'd0);

      // Back-pressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA1;
      tick();
      in_data = 8'hA2;
      tick();
      in_data = 8'hA3;
      chk("bp_occ", 32'(occupancy), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_hold_data", 32'(out_data), 32'hA1);
      chk("bp_hold_occ", 32'(occupancy), 32'd2);
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_rel_w1", 32'(out_data), 32'hA2);
      tick();
      chk("bp_rel_w2", 32'(out_data), 32'hA3);
      tick();
      chk("bp_empty", 32'(occupancy), 32'd0);

      // Bubble collapse behind a stalled output
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      tick();
      in_valid = 1'b0;
      tick();
      chk("bub_occ1", 32'(occupancy), 32'd1);
      chk("bub_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 8'h66;
      tick();
      chk("bub_occ2", 32'(occupancy), 32'd2);
      chk("bub_out", 32'(out_data), 32'h55);

      // Full pipe, simultaneous in and out
      out_ready = 1'b1;
      in_data   = 8'h77;
      #1;
      chk("full_io_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("full_io_occ", 32'(occupancy), 32'd2);
      chk("full_io_out", 32'(out_data), 32'h66);
      repeat (3) tick();
      chk("full_io_drain", 32'(occupancy), 32'd0);

      // Flush of a full pipe with a concurrent word
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h81;
      tick();
      in_data = 8'h82;
      tick();
      clr     = 1'b1;
      in_data = 8'h99;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("clr_occ", 32'(occupancy), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_data", 32'(out_data), 32'h00);
      // Flush of an empty pipe while the upstream sees acceptance
      out_ready = 1'b1;
      clr       = 1'b1;
      in_valid  = 1'b1;
      #1;
      chk("clr_in_ready", 32'(in_ready), 32'd1);
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      repeat (3) begin
         tick();
         chk("clr_no_leak", 32'(out_valid), 32'd0);
      end

      // DEPTH=4, WIDTH=16 flush restores RESET_VAL
      q_out_ready = 1'b0;
      q_in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         q_in_data = 16'h1000 + 16'(i);
         tick();
      end
      chk("d4_occ", 32'(q_occupancy), 32'd4);
      chk("d4_in_ready", 32'(q_in_ready), 32'd0);
      chk("d4_out", 32'(q_out_data), 32'h1000);
      q_in_data = 16'h0099;
      clr       = 1'b1;
      tick();
      clr        = 1'b0;
      q_in_valid = 1'b0;
      chk("d4_clr_occ", 32'(q_occupancy), 32'd0);
      chk("d4_clr_valid", 32'(q_out_valid), 32'd0);
      chk("d4_clr_data", 32'(q_out_data), 32'hFFFF);

      // Asynchronous reset in the middle of a stalled stream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hC1;
      tick();
      in_data = 8'hC2;
      tick();
      chk("mid_occ_pre", 32'(occupancy), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'h00);
      chk("mid_rst_occ", 32'(occupancy), 32'd0);
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_rel_rdy", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("mid_no_partial", 32'(out_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
